// File: rtl/mac_pkg.sv
// Shared types and default widths for the FIFO-draining dot-product engine.
package mac_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_ACC_WIDTH  = 24;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DONE
    } state_t;

endpackage

// File: rtl/mac_unit.sv
// Unsigned multiply-accumulate datapath: full-width product added into a
// wrapping accumulator under clear/enable control.
module mac_unit
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic [ACC_WIDTH-1:0]  acc
);

    logic [2*DATA_WIDTH-1:0] product;

    assign product = a_data * b_data;

    // NOTE: sequential state is written with <= only, so every flop samples
    // pre-edge values and process ordering can never create a race.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_WIDTH'(product);
        end
    end

endmodule

// File: rtl/fifo_mac_drain.sv
// Pops DEPTH operand pairs from two FIFOs and returns their dot product,
// stalling on either empty flag and pulsing done once the last product lands.
module fifo_mac_drain
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  a_empty,
    input  logic                  b_empty,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  rden,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  done,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   pop_cnt;
    logic               pending;
    logic               start_op;
    logic [ACC_WIDTH-1:0] acc;

    assign start_op = (state == IDLE) && start;
    assign done     = (state == DONE);
    assign busy     = (state != IDLE);

    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        next_state = state;
        rden       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = READ;
            end
            READ: begin
                rden = !a_empty && !b_empty && (pop_cnt < CNT_W'(DEPTH));
                // Leave only after the final popped word has been accumulated.
                if (pop_cnt == CNT_W'(DEPTH) && !pending) next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_cnt <= '0;
            pending <= 1'b0;
        end else if (start_op) begin
            pop_cnt <= '0;
            pending <= 1'b0;
        end else begin
            pop_cnt <= pop_cnt + CNT_W'(rden);
            pending <= rden;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
        end else if (state == READ && next_state == DONE) begin
            result <= acc;
        end
    end

    // FIFO read data arrives one cycle after rden, which is exactly when
    // pending is high.
    mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clear  (start_op),
        .en     (pending),
        .a_data (a_data),
        .b_data (b_data),
        .acc    (acc)
    );

endmodule

// File: tb/tb_fifo_mac_drain.sv
// Randomized self-checking bench: FIFO contents come from arrays, and expected
// results and done timing come from a sum-of-products model plus stall counting.
module tb_fifo_mac_drain;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 24;
    localparam int AW16  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            a_empty;
    logic            b_empty;
    logic [DW-1:0]   a_data;
    logic [DW-1:0]   b_data;
    logic            rden;
    logic [AW-1:0]   result;
    logic            done;
    logic            busy;
    logic            rden16;
    logic [AW16-1:0] result16;
    logic            done16;
    logic            busy16;

    int vectors    = 0;
    int miscompares = 0;

    int unsigned a_vals [DEPTH];
    int unsigned b_vals [DEPTH];

    always #5 clk = ~clk;

    fifo_mac_drain #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ACC_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .a_empty(a_empty), .b_empty(b_empty),
        .a_data(a_data), .b_data(b_data), .rden(rden), .result(result),
        .done(done), .busy(busy)
    );

    fifo_mac_drain #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ACC_WIDTH(AW16)) dut16 (
        .clk(clk), .rst(rst), .start(start), .a_empty(a_empty), .b_empty(b_empty),
        .a_data(a_data), .b_data(b_data), .rden(rden16), .result(result16),
        .done(done16), .busy(busy16)
    );

    function automatic longint unsigned exp_dot(input int width);
        longint unsigned sum = 0;
        for (int i = 0; i < DEPTH; i++) sum += longint'(a_vals[i]) * longint'(b_vals[i]);
        return sum % (64'd1 << width);
    endfunction

    // Runs one operation for a fixed window of cycles; cycle 0 is the start cycle.
    task automatic run_op(input int stall_pop, input int stall_len, input bit rand_empty,
                          input int repulse, output int done_cyc, output int done_cnt,
                          output longint unsigned rden_mask, output int stalls,
                          output int underflow);
        int pops = 0;
        int idx = 0;
        int stall_left = 0;
        bit rd_prev = 1'b0;
        done_cyc = -1;
        done_cnt = 0;
        rden_mask = 0;
        stalls = 0;
        underflow = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(posedge clk);
            #1;
            if (rd_prev && idx < DEPTH) begin
                a_data = DW'(a_vals[idx]);
                b_data = DW'(b_vals[idx]);
                idx++;
            end
            start   = (cyc == 0) || (cyc == repulse);
            a_empty = 1'b0;
            b_empty = 1'b0;
            if (stall_left > 0) begin
                b_empty = 1'b1;
                stall_left--;
            end
            if (rand_empty && cyc > 0) begin
                a_empty = ($urandom_range(0, 3) == 0);
                b_empty = b_empty || ($urandom_range(0, 3) == 0);
            end
            @(negedge clk);
            if (rden && (a_empty || b_empty)) underflow++;
            if (cyc >= 1 && pops < DEPTH && (a_empty || b_empty)) stalls++;
            if (rden) begin
                rden_mask[cyc] = 1'b1;
                pops++;
                if (pops == stall_pop) stall_left = stall_len;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            rd_prev = rden;
        end
        start   = 1'b0;
        a_empty = 1'b0;
        b_empty = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        a_empty = 1'b0;
        b_empty = 1'b0;
        a_data = '0;
        b_data = '0;
        #2;
        vectors++;
        if (busy !== 1'b0 || rden !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl busy/rden/done got %b%b%b want 000", busy, rden, done);
        end
        vectors++;
        if (result !== '0 || result16 !== '0) begin
            miscompares++;
            $display("FAIL reset_result got %0d/%0d want 0/0", result, result16);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_basic();
        int dc, dn, st, uf;
        longint unsigned rm;
        for (int i = 0; i < DEPTH; i++) begin a_vals[i] = i + 1; b_vals[i] = 2; end
        run_op(-1, 0, 1'b0, -1, dc, dn, rm, st, uf);
        vectors++;
        if (result !== AW'(72)) begin
            miscompares++;
            $display("FAIL basic_result got %0d want 72", result);
        end
        vectors++;
        if (dc !== 11 || dn !== 1) begin
            miscompares++;
            $display("FAIL basic_done cycle/count got %0d/%0d want 11/1", dc, dn);
        end
        vectors++;
        if (rm !== 64'h1FE) begin
            miscompares++;
            $display("FAIL basic_rden mask got %h want 1fe", rm);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_stall();
        int dc, dn, st, uf;
        longint unsigned rm;
        run_op(4, 3, 1'b0, -1, dc, dn, rm, st, uf);
        vectors++;
        if (result !== AW'(72)) begin
            miscompares++;
            $display("FAIL stall_result got %0d want 72", result);
        end
        vectors++;
        if (dc !== 14 || dn !== 1) begin
            miscompares++;
            $display("FAIL stall_done cycle/count got %0d/%0d want 14/1", dc, dn);
        end
        vectors++;
        if (rm !== 64'hF1E || uf !== 0) begin
            miscompares++;
            $display("FAIL stall_rden mask/underflow got %h/%0d want f1e/0", rm, uf);
        end
    endtask

    task automatic test_overflow();
        int dc, dn, st, uf;
        longint unsigned rm;
        for (int i = 0; i < DEPTH; i++) begin a_vals[i] = 255; b_vals[i] = 255; end
        run_op(-1, 0, 1'b0, -1, dc, dn, rm, st, uf);
        vectors++;
        if (result16 !== AW16'(61448)) begin
            miscompares++;
            $display("FAIL overflow_wrap16 got %0d want 61448", result16);
        end
        vectors++;
        if (result !== AW'(520200)) begin
            miscompares++;
            $display("FAIL overflow_full24 got %0d want 520200", result);
        end
    endtask

    task automatic test_restart_ignored();
        int dc, dn, st, uf;
        longint unsigned rm;
        for (int i = 0; i < DEPTH; i++) begin a_vals[i] = i + 1; b_vals[i] = 2; end
        run_op(-1, 0, 1'b0, 5, dc, dn, rm, st, uf);
        vectors++;
        if (dn !== 1 || dc !== 11) begin
            miscompares++;
            $display("FAIL restart_done count/cycle got %0d/%0d want 1/11", dn, dc);
        end
        vectors++;
        if (result !== AW'(72) || $countones(rm) !== DEPTH) begin
            miscompares++;
            $display("FAIL restart_result got %0d pops %0d want 72 pops 8", result, $countones(rm));
        end
    endtask

    task automatic test_back_to_back();
        int dc, dn, st, uf;
        longint unsigned rm;
        for (int i = 0; i < DEPTH; i++) begin a_vals[i] = 1; b_vals[i] = 3; end
        run_op(-1, 0, 1'b0, -1, dc, dn, rm, st, uf);
        vectors++;
        if (result !== AW'(24) || dc !== 11) begin
            miscompares++;
            $display("FAIL b2b_result got %0d at cycle %0d want 24 at 11", result, dc);
        end
    endtask

    task automatic test_reset_mid();
        int pops = 0;
        int dc, dn, st, uf;
        longint unsigned rm;
        for (int i = 0; i < DEPTH; i++) begin a_vals[i] = i + 1; b_vals[i] = 2; end
        for (int cyc = 0; cyc < 20 && pops < 4; cyc++) begin
            @(posedge clk);
            #1;
            start = (cyc == 0);
            @(negedge clk);
            if (rden) pops++;
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || rden !== 1'b0 || done !== 1'b0 || result !== '0) begin
            miscompares++;
            $display("FAIL midreset busy/rden/done/result got %b%b%b/%0d want 000/0",
                     busy, rden, done, result);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            a_vals[i] = $urandom_range(0, 255);
            b_vals[i] = $urandom_range(0, 255);
        end
        run_op(-1, 0, 1'b0, -1, dc, dn, rm, st, uf);
        vectors++;
        if (result !== AW'(exp_dot(AW)) || dc !== 11) begin
            miscompares++;
            $display("FAIL midreset_fresh got %0d at %0d want %0d at 11", result, dc, exp_dot(AW));
        end
    endtask

    task automatic test_random();
        int dc, dn, st, uf;
        longint unsigned rm;
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < DEPTH; i++) begin
                a_vals[i] = $urandom_range(0, 255);
                b_vals[i] = $urandom_range(0, 255);
            end
            run_op(-1, 0, 1'b1, -1, dc, dn, rm, st, uf);
            vectors++;
            if (result !== AW'(exp_dot(AW)) || result16 !== AW16'(exp_dot(AW16))) begin
                miscompares++;
                $display("FAIL random_result[%0d] got %0d/%0d want %0d/%0d", n,
                         result, result16, exp_dot(AW), exp_dot(AW16));
            end
            vectors++;
            if (dc !== DEPTH + 3 + st || dn !== 1) begin
                miscompares++;
                $display("FAIL random_done[%0d] cycle/count got %0d/%0d want %0d/1", n,
                         dc, dn, DEPTH + 3 + st);
            end
            vectors++;
            if (uf !== 0 || $countones(rm) !== DEPTH) begin
                miscompares++;
                $display("FAIL random_rden[%0d] underflow/pops got %0d/%0d want 0/%0d", n,
                         uf, $countones(rm), DEPTH);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_restart_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
